// File: rtl/grf.sv
// grf: 32 x 32-bit general register file with a committed-write log.
//   Register 0 always reads 0 and is never written.
//   Each committed write bumps WCnt and records its address and data in
//   LastA3/LastWD.
//   Define GRF_BYPASS_EN to forward same-cycle write data to the read ports.
//   Without it, a read of the register being written returns the old value.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low
//   WE, A3, WD     write enable / address / data
//   PC             PC of the writing instruction (simulation log only)
//   A1/RD1, A2/RD2 combinational read ports
//   WCnt           committed-write counter (WCNT_W bits, wraps)
//   LastA3, LastWD address and data of the most recent committed write
module grf #(
  parameter int unsigned WCNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [4:0]        A1,
  input  logic [4:0]        A2,
  input  logic [4:0]        A3,
  input  logic [31:0]       WD,
  input  logic [31:0]       PC,
  output logic [31:0]       RD1,
  output logic [31:0]       RD2,
  output logic [WCNT_W-1:0] WCnt,
  output logic [4:0]        LastA3,
  output logic [31:0]       LastWD
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic [DW-1:0]     r_regs [NREG];
  logic [WCNT_W-1:0] r_wcnt;
  logic [AW-1:0]     r_last_a3;
  logic [DW-1:0]     r_last_wd;

  logic              w_commit;
  logic [DW-1:0]     w_rd1;
  logic [DW-1:0]     w_rd2;

  // A write takes effect only outside reset and never to $0.
  assign w_commit = reset && WE && (A3 != AW'(0));

  // Register array, counter and last-write record.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
      r_wcnt    <= '0;
      r_last_a3 <= '0;
      r_last_wd <= '0;
    end else if (w_commit) begin
      r_regs[A3] <= WD;
      r_wcnt     <= r_wcnt + WCNT_W'(1);
      r_last_a3  <= A3;
      r_last_wd  <= WD;
    end
  end

  // Read ports; $0 is forced to zero and is never a forwarding target
  // because w_commit already excludes A3 == 0.
  always_comb begin
    w_rd1 = (A1 == AW'(0)) ? DW'(0) : r_regs[A1];
    w_rd2 = (A2 == AW'(0)) ? DW'(0) : r_regs[A2];
`ifdef GRF_BYPASS_EN
    if (w_commit && (A3 == A1)) w_rd1 = WD;
    if (w_commit && (A3 == A2)) w_rd2 = WD;
`endif
  end

  assign RD1    = w_rd1;
  assign RD2    = w_rd2;
  assign WCnt   = r_wcnt;
  assign LastA3 = r_last_a3;
  assign LastWD = r_last_wd;

`ifndef SYNTHESIS
  // Write log for simulation; $%d on the 5-bit address pads to two columns.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      $display("@%h: $%d <= %h", PC, A3, WD);
    end
  end
`endif

endmodule
